// File: rtl/count_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : count_capture
// Purpose  : Timestamp capture stage. Synchronises an asynchronous event
//            input, detects its rising edge, latches the free-running count
//            and queues the timestamp in a small FWFT FIFO that is read out
//            over a valid/ready handshake. A sticky flag records drops.
// Revision : 1.0 - initial release
// ============================================================================
module count_capture #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [31:0]   cnt_in,
  input  logic          evt_in,
  output logic [31:0]   ts_data,
  output logic          ts_valid,
  input  logic          ts_ready,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

  // Three-flop chain: two stages for metastability, third for edge history
  logic          r_s1;
  logic          r_s2;
  logic          r_s3;

  // Storage and pointers; pointers carry one extra wrap bit
  logic [31:0]   r_mem [DEPTH];
  logic [AW:0]   r_wp;
  logic [AW:0]   r_rp;
  logic          r_ovf;

  logic          w_evt_p;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  assign w_evt_p = r_s2 & ~r_s3;
  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) & (r_wp[AW] != r_rp[AW]);

  // A pop only happens on a visible head, so an entry written this cycle
  // can never be consumed before ts_valid has been presented for it.
  assign w_pop   = ~w_empty & ts_ready;

  // When full, a simultaneous pop frees the slot the new entry takes.
  assign w_push  = w_evt_p & (~w_full | w_pop);
  assign w_drop  = w_evt_p & w_full & ~w_pop;

  // Synchroniser and edge-history shift register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= evt_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Write/read pointer advance on push/pop
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + c_ptr_one;
      end
      if (w_pop) begin
        r_rp <= r_rp + c_ptr_one;
      end
    end
  end

  // Timestamp storage; contents need no reset since the pointers gate use
  always_ff @(posedge clk) begin
    if (w_push && rstn) begin
      r_mem[r_wp[AW-1:0]] <= cnt_in;
    end
  end

  // Sticky overflow flag; a new drop takes priority over a clear request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign ts_valid = ~w_empty;
  assign ts_data  = w_empty ? 32'd0 : r_mem[r_rp[AW-1:0]];
  assign level    = r_wp - r_rp;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_count_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_count_capture
// Purpose  : Self-checking bench for count_capture: cycle vector tables for
//            single capture and fill/overflow, directed sequences for the
//            multi-cycle corner cases, and a randomised backpressure run
//            against a queue reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_capture;

  logic          clk;
  logic          rstn;
  logic [31:0]   cnt_in;
  logic          evt_in;
  logic [31:0]   ts_data;
  logic          ts_valid;
  logic          ts_ready;
  logic [2:0]    level;
  logic          ovf;
  logic          ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  count_capture #(.DEPTH(4), .AW(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cnt_in   (cnt_in),
    .evt_in   (evt_in),
    .ts_data  (ts_data),
    .ts_valid (ts_valid),
    .ts_ready (ts_ready),
    .level    (level),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        evt;
    logic        rdy;
    logic        clr;
    logic [31:0] cnt;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  el;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic evt, input logic rdy, input logic clr,
                              input logic [31:0] cnt, input logic ev,
                              input logic [31:0] ed, input logic [2:0] el,
                              input logic eo);
    vec_t v;
    v.evt = evt; v.rdy = rdy; v.clr = clr; v.cnt = cnt;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then let the edge happen and settle
  task automatic drive(input logic evt, input logic rdy, input logic clr, input logic [31:0] cnt);
    evt_in   = evt;
    ts_ready = rdy;
    ovf_clr  = clr;
    cnt_in   = cnt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic ev, input logic [31:0] ed,
                         input logic [2:0] el, input logic eo);
    chk({nm, " valid"}, {31'd0, ts_valid}, {31'd0, ev});
    chk({nm, " data"},  ts_data, ed);
    chk({nm, " level"}, {29'd0, level}, {29'd0, el});
    chk({nm, " ovf"},   {31'd0, ovf}, {31'd0, eo});
  endtask

  // One randomised-run cycle checked against a queue reference
  logic [31:0] mq[$];
  logic        movf;
  logic [31:0] cntv;

  task automatic t5_cycle(input logic evt, input logic rdy, input logic push);
    logic pop_m;
    logic drop;
    evt_in   = evt;
    ts_ready = rdy;
    ovf_clr  = 1'b0;
    cnt_in   = cntv;
    #1;
    pop_m = (mq.size() > 0) && rdy;
    if (pop_m) chk("T5 pop data", ts_data, mq[0]);
    drop = push && (mq.size() == 4) && !pop_m;
    @(posedge clk);
    #1;
    if (pop_m) void'(mq.pop_front());
    if (push && !drop) mq.push_back(cntv);
    if (drop) movf = 1'b1;
    cntv = cntv + 32'd1;
    chk("T5 valid", {31'd0, ts_valid}, {31'd0, (mq.size() > 0)});
    chk("T5 level", {29'd0, level}, mq.size());
    chk("T5 data",  ts_data, (mq.size() > 0) ? mq[0] : 32'd0);
    chk("T5 ovf",   {31'd0, ovf}, {31'd0, movf});
  endtask

  initial begin
    rstn = 1'b0; evt_in = 1'b0; ts_ready = 1'b0; ovf_clr = 1'b0; cnt_in = 32'd0;

    // ---------------- Reset state ----------------
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk_all("RST", 1'b0, 32'd0, 3'd0, 1'b0);
    rstn = 1'b1;

    // ---------------- T1 single event (table) ----------------
    add(1, 0, 0, 100, 0, 0,   0, 0);
    add(1, 0, 0, 101, 0, 0,   0, 0);
    add(1, 0, 0, 102, 1, 102, 1, 0);
    add(0, 0, 0, 103, 1, 102, 1, 0);
    add(0, 1, 0, 104, 0, 0,   0, 0);

    // ---------------- T2 fill and overflow (table) ----------------
    for (int e = 0; e < 5; e++) begin
      for (int p = 0; p < 4; p++) begin
        int n;
        int w;
        int l;
        n = e * 4 + p;
        w = (n < 2) ? 0 : ((n - 2) / 4 + 1);
        l = (w > 4) ? 4 : w;
        add(p < 2, 0, 0, 200 + n, l > 0, (l > 0) ? 32'd202 : 32'd0, 3'(l), w >= 5);
      end
    end
    add(0, 1, 0, 0, 1, 206, 3, 1);
    add(0, 1, 0, 0, 1, 210, 2, 1);
    add(0, 1, 0, 0, 1, 214, 1, 1);
    add(0, 1, 0, 0, 0, 0,   0, 1);
    add(0, 0, 1, 0, 0, 0,   0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].evt, tbl[i].rdy, tbl[i].clr, tbl[i].cnt);
      chk_all($sformatf("VEC%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].eo);
    end

    // ---------------- T3 full + pop + event ----------------
    for (int e = 0; e < 4; e++) begin
      drive(1, 0, 0, 300 + 4 * e);
      drive(1, 0, 0, 301 + 4 * e);
      drive(0, 0, 0, 302 + 4 * e);
      drive(0, 0, 0, 303 + 4 * e);
    end
    chk_all("T3 full", 1'b1, 32'd302, 3'd4, 1'b0);
    drive(1, 0, 0, 400);
    drive(1, 0, 0, 401);
    drive(0, 1, 0, 402);
    chk_all("T3 push+pop", 1'b1, 32'd306, 3'd4, 1'b0);
    drive(0, 0, 0, 403);
    chk("T3 stall data", ts_data, 32'd306);
    drive(0, 1, 0, 0);
    chk("T3 head2", ts_data, 32'd310);
    drive(0, 1, 0, 0);
    chk("T3 head3", ts_data, 32'd314);
    drive(0, 1, 0, 0);
    chk("T3 last", ts_data, 32'd402);
    drive(0, 1, 0, 0);
    chk_all("T3 drained", 1'b0, 32'd0, 3'd0, 1'b0);

    // ---------------- T4 count wrap ----------------
    drive(1, 0, 0, 32'hFFFF_FFFE);
    drive(1, 0, 0, 32'hFFFF_FFFE);
    drive(0, 0, 0, 32'hFFFF_FFFF);
    drive(0, 0, 0, 32'hFFFF_FFFF);
    drive(1, 0, 0, 32'hFFFF_FFFF);
    drive(1, 0, 0, 32'hFFFF_FFFF);
    drive(0, 0, 0, 32'h0000_0000);
    drive(0, 0, 0, 32'h0000_0001);
    chk_all("T4 first", 1'b1, 32'hFFFF_FFFF, 3'd2, 1'b0);
    drive(0, 1, 0, 0);
    chk_all("T4 second", 1'b1, 32'h0000_0000, 3'd1, 1'b0);
    drive(0, 1, 0, 0);
    chk_all("T4 empty", 1'b0, 32'd0, 3'd0, 1'b0);

    // ---------------- T5 random backpressure ----------------
    movf = 1'b0;
    cntv = 32'h0000_1000;
    for (int ev = 0; ev < 1000; ev++) begin
      int low;
      low = $urandom_range(2, 6);
      for (int p = 0; p < 2 + low; p++) begin
        t5_cycle(p < 2, 1'($urandom_range(0, 1)), p == 2);
      end
    end

    // ---------------- T6 clear races and reset ----------------
    for (int i = 0; i < 6; i++) drive(0, 1, 1, 0);
    chk_all("T6 start", 1'b0, 32'd0, 3'd0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      drive(1, 0, 0, 500 + 4 * e);
      drive(1, 0, 0, 501 + 4 * e);
      drive(0, 0, 0, 502 + 4 * e);
      drive(0, 0, 0, 503 + 4 * e);
    end
    drive(1, 0, 0, 600);
    drive(1, 0, 0, 601);
    drive(0, 0, 1, 602);
    chk_all("T6 clr+drop", 1'b1, 32'd502, 3'd4, 1'b1);
    drive(0, 0, 1, 603);
    chk("T6 clr alone", {31'd0, ovf}, 32'd0);
    drive(1, 0, 0, 610);
    drive(1, 0, 0, 611);
    drive(0, 0, 0, 612);
    drive(0, 0, 0, 613);
    chk_all("T6 drop", 1'b1, 32'd502, 3'd4, 1'b1);
    drive(0, 1, 0, 0);
    chk_all("T6 three", 1'b1, 32'd506, 3'd3, 1'b1);
    drive(1, 0, 0, 650);
    drive(1, 0, 0, 651);
    rstn = 1'b0;
    drive(1, 0, 0, 652);
    chk_all("T6 reset", 1'b0, 32'd0, 3'd0, 1'b0);
    rstn = 1'b1;
    drive(1, 0, 0, 700);
    drive(1, 0, 0, 701);
    chk("T6 no early capture", {29'd0, level}, 32'd0);
    drive(1, 0, 0, 702);
    chk_all("T6 post-reset capture", 1'b1, 32'd702, 3'd1, 1'b0);
    drive(1, 0, 0, 703);
    drive(0, 0, 0, 704);
    drive(0, 0, 0, 705);
    chk_all("T6 single capture", 1'b1, 32'd702, 3'd1, 1'b0);
    drive(0, 1, 0, 0);
    chk_all("T6 end", 1'b0, 32'd0, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
